// File: rtl/packet_router.sv
// ---------------------------------------------------------------------------
// packet_router
//   Routes a stream of 13-bit flits to one of four output FIFOs. Routing is
//   decided on the head flit of each packet. Later flits follow the locked
//   port until the eop flit arrives. Head flits of type 2'b11 cause the whole
//   packet to be discarded.
//
//   Flit layout: {dest[12:11], type[10:9], payload[8:1], eop[0]}
//
//   Parameters
//     FIFO_DEPTH   entries per output FIFO (power of two, 2..16)
//
//   Ports
//     clk          single clock, rising edge
//     rst_n        asynchronous active-low reset
//     in_valid     input flit valid
//     in_packet    input flit
//     in_ready     input flit accepted when in_valid && in_ready (combinational)
//     out_valid    per-port FIFO non-empty
//     out_packet   per-port head flit, port p at [13p+12:13p]
//     out_ready    per-port pop request, honoured only when out_valid[p]
//     pkt_count    completed packets routed
//     drop_count   completed packets dropped
//
//   Build option
//     PKT_ROUTER_STATS_EN  when defined, pkt_count/drop_count are live
//                          wrapping counters; otherwise they are tied to 0
//                          and no counter state exists.
// ---------------------------------------------------------------------------

// Per-port first-word-fall-through FIFO. The head entry is presented directly
// from storage, so a flit written at edge N is visible right after edge N.
module pr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_valid   = !w_empty;
  assign o_data    = r_mem[r_rptr];

  // A full FIFO refuses the push even if the head is popped this cycle.
  assign w_do_push = i_push && !o_full;
  // Pops against an empty FIFO are ignored.
  assign w_do_pop  = i_pop && !w_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end
endmodule

module packet_router #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [12:0] in_packet,
  output logic        in_ready,
  output logic [3:0]  out_valid,
  output logic [51:0] out_packet,
  input  logic [3:0]  out_ready,
  output logic [7:0]  pkt_count,
  output logic [7:0]  drop_count
);
  localparam int NUM_PORTS = 4;
  localparam int FLIT_W    = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,   // awaiting a head flit
    S_ROUTE = 2'd1,   // mid-packet, output port locked
    S_DROP  = 2'd2    // mid-packet, discarding
  } state_t;

  state_t r_state;
  logic [1:0] r_lock;

  logic [1:0] w_dest;
  logic [1:0] w_type;
  logic       w_eop;
  logic       w_head_drop;
  logic       w_rdy;
  logic       w_acc;
  logic       w_route;
  logic [1:0] w_tgt;

  logic [NUM_PORTS-1:0]             w_push;
  logic [NUM_PORTS-1:0]             w_full;
  logic [NUM_PORTS-1:0][FLIT_W-1:0] w_head;

  assign w_dest = in_packet[12:11];
  assign w_type = in_packet[10:9];
  assign w_eop  = in_packet[0];

  // A type-3 head discards the whole packet, whatever its dest says.
  assign w_head_drop = (r_state == S_IDLE) && (w_type == 2'b11);

  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      S_IDLE:  w_rdy = !w_full[w_dest] || (w_type == 2'b11);
      S_ROUTE: w_rdy = !w_full[r_lock];
      S_DROP:  w_rdy = 1'b1;
      default: w_rdy = 1'b0;
    endcase
  end

  // Nothing is accepted while reset is held.
  assign in_ready = rst_n && w_rdy;
  assign w_acc    = in_valid && in_ready;

  // Accepted flits either go to a FIFO (routed) or vanish (dropped).
  assign w_route = w_acc && ((r_state == S_ROUTE) ||
                             ((r_state == S_IDLE) && !w_head_drop));
  // Mid-packet flits ignore their own dest field.
  assign w_tgt   = (r_state == S_ROUTE) ? r_lock : w_dest;

  always_comb begin
    w_push = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      w_push[p] = w_route && (w_tgt == 2'(p));
  end

  // Flit-level FSM. Single-flit packets (eop on the head) never leave IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lock  <= '0;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (!w_head_drop) r_lock <= w_dest;
          if (!w_eop)       r_state <= w_head_drop ? S_DROP : S_ROUTE;
        end
        S_ROUTE, S_DROP: begin
          if (w_eop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    pr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FLIT_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[p]),
      .i_data  (in_packet),
      .i_pop   (out_ready[p]),
      .o_valid (out_valid[p]),
      .o_full  (w_full[p]),
      .o_data  (w_head[p])
    );
  end

  assign out_packet = w_head;

`ifdef PKT_ROUTER_STATS_EN
  logic [7:0] r_pkt_cnt;
  logic [7:0] r_drop_cnt;

  // A packet is counted when its eop flit is accepted; a dropped packet is
  // any accepted flit that did not go to a FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_route && w_eop)           r_pkt_cnt  <= r_pkt_cnt + 8'd1;
      if (w_acc && !w_route && w_eop) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign pkt_count  = r_pkt_cnt;
  assign drop_count = r_drop_cnt;
`else
  assign pkt_count  = 8'h00;
  assign drop_count = 8'h00;
`endif
endmodule

// File: tb/tb_packet_router.sv
// Directed bench for packet_router (FIFO_DEPTH = 4): a vector table for the
// per-cycle routing/drop behaviour, then hand sequences for FIFO full,
// mid-packet reset and pointer wrap.
module tb_packet_router;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [12:0] in_packet;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [51:0] out_packet;
  logic [3:0]  out_ready;
  logic [7:0]  pkt_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int fails  = 0;

`ifdef PKT_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  packet_router #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_packet  (in_packet),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_packet (out_packet),
    .out_ready  (out_ready),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [12:0] pkt;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    int          port;      // -1: no head check
    logic [12:0] exp_head;
    string       name;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [12:0] mk(input logic [1:0] d, input logic [1:0] t,
                                     input logic [7:0] pl, input logic e);
    return {d, t, pl, e};
  endfunction

  function automatic vec_t V(input logic vld, input logic [12:0] pkt,
                             input logic [3:0] ordy, input logic rdy,
                             input logic [3:0] ov, input int port,
                             input logic [12:0] head, input string nm);
    vec_t v;
    v.vld = vld; v.pkt = pkt; v.ordy = ordy; v.exp_rdy = rdy;
    v.exp_ov = ov; v.port = port; v.exp_head = head; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] head(input int p);
    return out_packet[p*13 +: 13];
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_packet = '0; out_ready = '0;

    // ---------------- reset state ----------------
    cyc(); cyc();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
    chk("rst_pkt_count", {24'b0, pkt_count}, 32'd0);
    chk("rst_drop_count", {24'b0, drop_count}, 32'd0);
    #2 rst_n = 1'b1;
    cyc();

    // ---------------- vector table ----------------
    vecs[0]  = V(1, 13'b10_00_10101010_1, 4'b0000, 1, 4'b0100, 2, 13'b10_00_10101010_1, "single_route");
    vecs[1]  = V(0, 13'd0, 4'b0100, 1, 4'b0000, -1, 13'd0, "single_pop");
    vecs[2]  = V(1, mk(1,0,8'h11,0), 4'b0000, 1, 4'b0010, 1, mk(1,0,8'h11,0), "lock_head");
    vecs[3]  = V(1, mk(3,1,8'h22,0), 4'b0000, 1, 4'b0010, 1, mk(1,0,8'h11,0), "lock_body");
    vecs[4]  = V(1, mk(3,2,8'h33,1), 4'b0000, 1, 4'b0010, 1, mk(1,0,8'h11,0), "lock_tail");
    vecs[5]  = V(0, 13'd0, 4'b0010, 1, 4'b0010, 1, mk(3,1,8'h22,0), "lock_pop1");
    vecs[6]  = V(0, 13'd0, 4'b0010, 1, 4'b0010, 1, mk(3,2,8'h33,1), "lock_pop2");
    vecs[7]  = V(0, 13'd0, 4'b0010, 1, 4'b0000, -1, 13'd0, "lock_pop3");
    vecs[8]  = V(1, mk(0,3,8'h44,0), 4'b0000, 1, 4'b0000, -1, 13'd0, "drop_head");
    vecs[9]  = V(1, mk(2,0,8'h55,1), 4'b0000, 1, 4'b0000, -1, 13'd0, "drop_tail");
    vecs[10] = V(1, mk(0,0,8'h66,1), 4'b0000, 1, 4'b0001, 0, mk(0,0,8'h66,1), "after_drop");
    vecs[11] = V(0, 13'd0, 4'b1111, 1, 4'b0000, -1, 13'd0, "pop_all_ready");

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].vld; in_packet = vecs[i].pkt; out_ready = vecs[i].ordy;
      #1 chk({vecs[i].name, "_rdy"}, {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
      cyc();
      chk({vecs[i].name, "_ov"}, {28'b0, out_valid}, {28'b0, vecs[i].exp_ov});
      if (vecs[i].port >= 0)
        chk({vecs[i].name, "_head"}, {19'b0, head(vecs[i].port)}, {19'b0, vecs[i].exp_head});
    end
    chk("tbl_pkt_count", {24'b0, pkt_count}, STATS ? 32'd3 : 32'd0);
    chk("tbl_drop_count", {24'b0, drop_count}, STATS ? 32'd1 : 32'd0);

    // ---------------- FIFO full / no bypass ----------------
    in_valid = 1'b0; out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_packet = mk(2, 0, 8'(i), 1);
      #1 chk("full_acc", {31'b0, in_ready}, 32'd1);
      cyc();
    end
    in_packet = mk(2, 0, 8'hA4, 1);
    #1 chk("full_refuse", {31'b0, in_ready}, 32'd0);
    chk("full_ov", {28'b0, out_valid}, 32'b0100);
    out_ready = 4'b0100;
    #1 chk("full_no_bypass", {31'b0, in_ready}, 32'd0);
    cyc();
    out_ready = '0;
    #1 chk("full_after_pop", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("full_head", {19'b0, head(2)}, {19'b0, mk(2,0,8'h01,1)});
    // Discard head is always ready even towards a full port.
    in_packet = mk(2, 3, 8'hDD, 1);
    #1 chk("full_drop_rdy", {31'b0, in_ready}, 32'd1);
    cyc();
    // Port 1 works and drains while port 2 stays blocked.
    in_packet = mk(1, 0, 8'h77, 1);
    #1 chk("indep_rdy", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("indep_ov", {28'b0, out_valid}, 32'b0110);
    in_valid = 1'b0; out_ready = 4'b0010;
    cyc();
    chk("indep_pop", {28'b0, out_valid}, 32'b0100);
    begin
      logic [7:0] exp_pl [4];
      exp_pl[0] = 8'h01; exp_pl[1] = 8'h02; exp_pl[2] = 8'h03; exp_pl[3] = 8'hA4;
      out_ready = 4'b0100;
      for (int k = 0; k < 4; k++) begin
        chk("drain_head", {19'b0, head(2)}, {19'b0, mk(2, 0, exp_pl[k], 1)});
        cyc();
      end
    end
    out_ready = '0;
    chk("drain_empty", {28'b0, out_valid}, 32'd0);
    chk("full_pkt_count", {24'b0, pkt_count}, STATS ? 32'd9 : 32'd0);
    chk("full_drop_count", {24'b0, drop_count}, STATS ? 32'd2 : 32'd0);

    // ---------------- reset mid-packet ----------------
    in_valid = 1'b1; in_packet = mk(1, 0, 8'h10, 0);
    cyc();
    in_packet = mk(2, 0, 8'h11, 0);    // follows lock to port 1
    cyc();
    chk("mid_ov", {28'b0, out_valid}, 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", {28'b0, out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_pkt", {24'b0, pkt_count}, 32'd0);
    cyc();
    #2 rst_n = 1'b1;
    in_packet = mk(0, 0, 8'h12, 1);
    #1 chk("post_rst_rdy", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("post_rst_ov", {28'b0, out_valid}, 32'b0001);
    chk("post_rst_head", {19'b0, head(0)}, {19'b0, mk(0,0,8'h12,1)});
    in_valid = 1'b0; out_ready = 4'b0001;
    cyc();
    out_ready = '0;

    // ---------------- pointer wrap ----------------
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_packet = mk(3, 0, 8'(i), 1);
      #1 chk("wrap_rdy", {31'b0, in_ready}, 32'd1);
      cyc();
      chk("wrap_ov", {28'b0, out_valid}, 32'b1000);
      chk("wrap_head", {19'b0, head(3)}, {19'b0, mk(3, 0, 8'(i), 1)});
    end
    in_valid = 1'b0;
    cyc();
    chk("wrap_empty", {28'b0, out_valid}, 32'd0);
    chk("wrap_pkt_count", {24'b0, pkt_count}, STATS ? 32'd20 : 32'd0);
    chk("wrap_drop_count", {24'b0, drop_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
